moore_seq_gen: RTL and testbench
================================

# moore_seq_gen

Moore-style serial pattern generator that drives the single-bit `w` stream consumed by the team's sequence-detector FSMs such as `moore_fsm_2`. It captures a parallel pattern on a start request, shifts it out MSB-first one bit per clock, and repeats it a programmable number of times with an idle gap between repetitions. It then pulses `done` and returns to idle. All outputs are registered and depend on state only, with no combinational input-to-output paths. It is the transmit end for detector loopback benches and for on-chip self-test.

## Interface
- `WIDTH`, 8: pattern length in bits, ≥2.
- `REPS_W`, 4: width of the repetition-count input.
- `GAP`, 2: idle cycles between repetitions, ≥0.

- `Clock` in 1: rising-edge clock.
- `Reset` in 1: one clock; reset is asynchronous and active-high.
- `start` in 1: request; sampled only while idle.
- `pattern` in WIDTH: word to send; captured when `start` is accepted.
- `reps` in REPS_W: number of repetitions; 0 is treated as 1.
- `busy` out 1: high in every non-IDLE state.
- `w` out 1: serial data; 0 whenever `w_valid`=0.
- `w_valid` out 1: high while a pattern bit (or parity bit) is on `w`.
- `done` out 1: one-cycle pulse after the final bit.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
  - IDLE: outputs 0. `start`=1 at an edge captures `pattern` into the shift register and `max(reps,1)` into the rep counter, clears the bit counter, and moves to SHIFT.
  - SHIFT: `w` = shift-register MSB and `w_valid`=1. Each edge shifts left and increments the bit counter. After the last bit (WIDTH bits, plus parity if enabled):
    - if the rep counter is greater than 1: decrement it, reload the shift register from the captured copy, and go to GAP, or directly to SHIFT when GAP=0;
    - otherwise go to DONE.
  - GAP: `w`=0, `w_valid`=0. Stays GAP cycles, then SHIFT.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in SHIFT, GAP and DONE.
- `start` is ignored outside IDLE, including in the DONE cycle.
- Changes on `pattern` or `reps` after acceptance have no effect.
- Counters are sized by `$clog2`. There is no wrap-around: the bit counter is cleared on every reload, and the rep counter never decrements below 1.
- Reset asserted mid-operation: state goes to IDLE and all outputs go to 0 immediately (asynchronously). The frame is abandoned. There is no `done` pulse.
- Reset deasserted with `start`=1: the request is accepted at the first rising edge after deassertion.

## Timing
- Reset values: `busy`=0, `w`=0, `w_valid`=0, `done`=0, state IDLE, all counters 0.
- Start accepted at edge E0:
  - first bit valid from E0 to E1;
  - bit k is valid in cycle k+1, for k=0..WIDTH-1.
- One repetition occupies WIDTH cycles, or WIDTH+1 with parity enabled.
- Total busy cycles = R·L + (R−1)·GAP + 1, where L is the frame length in bits and R = max(`reps`,1).
- The earliest next accepted `start` is one cycle after `done`.

## Configuration
- `SEQ_GEN_PARITY_EN`
  - Defined: each repetition appends one even-parity bit (XOR of the captured `pattern`) immediately after the LSB, with `w_valid`=1. Frame length is WIDTH+1.
  - Undefined: no parity bit, no parity logic, and frame length is WIDTH.

## Test plan
- Reset, then idle with `start`=0 for 5 cycles -> all outputs 0 throughout.
- `pattern`=8'b0110_1110, `reps`=1, GAP=2 -> `w` = 0,1,1,0,1,1,1,0 in cycles 1–8 with `w_valid`=1; `done`=1 in cycle 9 only; `busy` high in cycles 1–9.
- Same pattern, `reps`=2 -> pattern in cycles 1–8; `w`=0 and `w_valid`=0 in cycles 9–10; pattern again in cycles 11–18; `done` in cycle 19. `reps`=0 produces the same waveform as `reps`=1.
- `start` held high continuously and `pattern` changed to 8'hFF in cycle 3 -> the first frame still sends 0x6E. A second frame starts one cycle after `done`.
- With `SEQ_GEN_PARITY_EN` and `pattern`=8'b0110_1110 (five 1s) -> 9th bit `w`=1; `done` in cycle 10.
- `reps`=3, `Reset` asserted mid-cycle during cycle 5 -> outputs go to 0 asynchronously, no `done`. Loopback into `moore_fsm_2` with 8'b0011_1000 -> `z` rises after the second consecutive 1 (within 1 cycle of w-bit 3) and falls after `w` returns to 0.

Source files
------------

// File: rtl/moore_seq_gen_if.sv
// ---------------------------------------------------------------------------
// moore_seq_gen_if
// Request / serial-stream bundle for the moore_seq_gen pattern generator.
//   start   : request, sampled only while the generator is idle
//   pattern : WIDTH-bit word to send, captured when start is accepted
//   reps    : repetition count (0 behaves as 1)
//   busy    : generator is in a non-idle state
//   w       : serial data bit, 0 whenever w_valid is low
//   w_valid : a pattern (or parity) bit is on w
//   done    : one-cycle pulse after the final bit
// master modport : requester side; slave modport : generator side.
// ---------------------------------------------------------------------------
interface moore_seq_gen_if #(
    parameter int WIDTH  = 8,
    parameter int REPS_W = 4
);
    logic              start;
    logic [WIDTH-1:0]  pattern;
    logic [REPS_W-1:0] reps;
    logic              busy;
    logic              w;
    logic              w_valid;
    logic              done;

    modport master (
        output start, pattern, reps,
        input  busy, w, w_valid, done
    );

    modport slave (
        input  start, pattern, reps,
        output busy, w, w_valid, done
    );
endinterface

// File: rtl/moore_seq_gen.sv
// ---------------------------------------------------------------------------
// moore_seq_gen
// Moore serial pattern generator. Captures a parallel pattern on start,
// shifts it out MSB-first, repeats it max(reps,1) times with GAP idle cycles
// between repetitions, then pulses done and returns to idle.
// Ports:
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : moore_seq_gen_if.slave (start/pattern/reps in, busy/w/w_valid/done out)
// Optional feature macro: SEQ_GEN_PARITY_EN -- appends an even-parity bit
// after the LSB of every repetition (frame length WIDTH+1).
// ---------------------------------------------------------------------------
module moore_seq_gen #(
    parameter int WIDTH  = 8,
    parameter int REPS_W = 4,
    parameter int GAP    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    moore_seq_gen_if.slave bus
);
`ifdef SEQ_GEN_PARITY_EN
    localparam int FRAME_L = WIDTH + 1;
`else
    localparam int FRAME_L = WIDTH;
`endif
    localparam int BIT_W = $clog2(FRAME_L);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_L - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t              r_state, w_state_n;
    logic [FRAME_L-1:0]  r_shift, w_shift_n;
    logic [FRAME_L-1:0]  r_pat, w_pat_n;
    logic [BIT_W-1:0]    r_bit, w_bit_n;
    logic [REPS_W-1:0]   r_rep, w_rep_n;
    logic [GAP_W-1:0]    r_gap, w_gap_n;
    logic                r_busy, r_w, r_w_valid, r_done;
    logic                w_busy_n, w_w_n, w_valid_n, w_done_n;
    logic [FRAME_L-1:0]  w_load;

    // The parity bit rides at the LSB of the frame word so it leaves the
    // shifter right after the pattern LSB with no extra muxing.
`ifdef SEQ_GEN_PARITY_EN
    assign w_load = {bus.pattern, ^bus.pattern};
`else
    assign w_load = bus.pattern;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_pat     <= '0;
            r_bit     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            r_busy    <= 1'b0;
            r_w       <= 1'b0;
            r_w_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_pat     <= w_pat_n;
            r_bit     <= w_bit_n;
            r_rep     <= w_rep_n;
            r_gap     <= w_gap_n;
            r_busy    <= w_busy_n;
            r_w       <= w_w_n;
            r_w_valid <= w_valid_n;
            r_done    <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_pat_n   = r_pat;
        w_bit_n   = r_bit;
        w_rep_n   = r_rep;
        w_gap_n   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pat_n   = w_load;
                    w_shift_n = w_load;
                    w_rep_n   = (bus.reps == '0) ? REPS_W'(1) : bus.reps;
                    w_bit_n   = '0;
                    w_state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bit == BIT_LAST) begin
                    if (r_rep > REPS_W'(1)) begin
                        w_rep_n   = r_rep - 1'b1;
                        w_shift_n = r_pat;
                        w_bit_n   = '0;
                        w_gap_n   = '0;
                        w_state_n = (GAP == 0) ? S_SHIFT : S_GAP;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end else begin
                    w_shift_n = {r_shift[FRAME_L-2:0], 1'b0};
                    w_bit_n   = r_bit + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_n = S_SHIFT;
                end else begin
                    w_gap_n = r_gap + 1'b1;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values, so they line up with
    // the state they describe while having no input-to-output path.
    always_comb begin
        w_busy_n  = (w_state_n != S_IDLE);
        w_valid_n = (w_state_n == S_SHIFT);
        w_w_n     = w_valid_n & w_shift_n[FRAME_L-1];
        w_done_n  = (w_state_n == S_DONE);
    end

    assign bus.busy    = r_busy;
    assign bus.w       = r_w;
    assign bus.w_valid = r_w_valid;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_moore_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_gen
// Directed bench for moore_seq_gen (WIDTH=8, REPS_W=4, GAP=2). Output tuple
// checked each cycle is {busy, w_valid, w, done}. Honours SEQ_GEN_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_moore_seq_gen;
    localparam int WIDTH  = 8;
    localparam int REPS_W = 4;
    localparam int GAP    = 2;
`ifdef SEQ_GEN_PARITY_EN
    localparam int L = 9;
`else
    localparam int L = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    moore_seq_gen_if #(.WIDTH(WIDTH), .REPS_W(REPS_W)) bus ();

    moore_seq_gen #(.WIDTH(WIDTH), .REPS_W(REPS_W), .GAP(GAP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.busy, bus.w_valid, bus.w, bus.done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: busy/valid/w/done observed=%b expected=%b at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    // Called in cycle 1 of an accepted frame; returns in the cycle after done.
    task automatic expect_frames(input logic [7:0] pat, input int r);
        logic b;
        for (int rep = 0; rep < r; rep++) begin
            for (int k = 0; k < L; k++) begin
                b = (k < 8) ? pat[7-k] : ^pat;
                expect_out("shift", {1'b1, 1'b1, b, 1'b0});
                tick();
            end
            if (rep < r - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    expect_out("gap", 4'b1000);
                    tick();
                end
            end
        end
        expect_out("done", 4'b1001);
        tick();
    endtask

    initial begin
        logic [7:0] p6e;
        logic       b;
        p6e         = 8'b0110_1110;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.reps    = '0;

        // Reset state, then 5 idle cycles
        tick();
        tick();
        expect_out("reset", 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("idle", 4'b0000);
        end

        // reps=1
        bus.pattern = p6e;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_frames(p6e, 1);
        expect_out("idle_after_r1", 4'b0000);

        // reps=2 with gap
        bus.reps  = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_frames(p6e, 2);
        expect_out("idle_after_r2", 4'b0000);

        // reps=0 behaves as 1
        bus.reps  = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_frames(p6e, 1);
        expect_out("idle_after_r0", 4'b0000);

        // start held high, pattern/reps changed mid-frame
        bus.pattern = p6e;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        tick();
        for (int k = 0; k < L; k++) begin
            if (k == 2) begin
                bus.pattern = 8'hFF;
                bus.reps    = 4'd3;
            end
            b = (k < 8) ? p6e[7-k] : ^p6e;
            expect_out("held_frame", {1'b1, 1'b1, b, 1'b0});
            tick();
        end
        expect_out("held_done", 4'b1001);
        bus.reps = 4'd1;
        tick();
        expect_out("held_idle", 4'b0000);
        tick();
        bus.start = 1'b0;
        expect_frames(8'hFF, 1);
        expect_out("idle_after_ff", 4'b0000);

        // reps=3, reset asserted mid-cycle during cycle 5
        bus.pattern = p6e;
        bus.reps    = 4'd3;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_out("pre_reset", {1'b1, 1'b1, p6e[7-k], 1'b0});
            tick();
        end
        expect_out("cycle5", {1'b1, 1'b1, p6e[3], 1'b0});
        #1;
        rst = 1'b1;
        #1;
        expect_out("async_reset", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("held_reset", 4'b0000);
        end

        // release reset with start already high: accepted at first edge
        bus.pattern = 8'b0011_1000;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        tick();
        expect_out("reset_start", 4'b0000);
        #1;
        rst = 1'b0;
        tick();
        bus.start = 1'b0;
        expect_frames(8'b0011_1000, 1);
        expect_out("final_idle", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
